// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner encoding,
// default widths and the round-robin owner pick.
package mem_port_arbiter_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_LINE_W = 256;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DONE    = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } arb_owner_t;

   // When both sides are pending, the side that was not served last wins.
   function automatic arb_owner_t pick_owner(input logic       pend_i,
                                             input logic       pend_d,
                                             input arb_owner_t last_served);
      arb_owner_t owner;
      if (pend_i && pend_d) begin
         owner = (last_served == OWNER_I) ? OWNER_D : OWNER_I;
      end else if (pend_d) begin
         owner = OWNER_D;
      end else begin
         owner = OWNER_I;
      end
      return owner;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_req_latch.sv
// Request latch: captures address, operation and write data of the granted
// requester and presents them as the shared-port command until cleared.
// Ports: clk, rst (sync, active-high), grant/clear controls, captured inputs
// (op_write, addr, wdata), latched outputs (valid, is_write, lat_addr, lat_wdata).
module mem_port_arbiter_req_latch
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned LINE_W = DEF_LINE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              grant,
   input  logic              clear,
   input  logic              op_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LINE_W-1:0] wdata,
   output logic              valid,
   output logic              is_write,
   output logic [ADDR_W-1:0] lat_addr,
   output logic [LINE_W-1:0] lat_wdata
);

   // Reset and completion both empty the latch so the port idles at zero.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         valid     <= 1'b0;
         is_write  <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (grant) begin
         valid     <= 1'b1;
         is_write  <= op_write;
         lat_addr  <= addr;
         lat_wdata <= wdata;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single physical memory port between the I-cache miss path
// and the D-cache miss/writeback path. One owner at a time; the owner's
// request is latched, driven onto pmem_* until pmem_resp, and the response
// is routed back to the owner only.
// Ports: clk, rst (sync, active-high); I side (i_read, i_addr, i_rdata, i_resp);
// D side (d_read, d_write, d_addr, d_wdata, d_rdata, d_resp); shared port
// (pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_rdata, pmem_resp).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned LINE_W = DEF_LINE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t state;
   arb_owner_t last_served;

   logic              pend_i;
   logic              pend_d;
   logic              grant;
   arb_owner_t        grant_owner;
   logic              grant_write;
   logic [ADDR_W-1:0] grant_addr;
   logic [LINE_W-1:0] grant_wdata;
   logic              serve_done;
   logic              lat_valid;
   logic              lat_write;

   // Grant decision, only meaningful in IDLE.
   always_comb begin
      pend_i      = i_read;
      pend_d      = d_read | d_write;
      grant       = (state == IDLE) && (pend_i || pend_d);
      grant_owner = pick_owner(pend_i, pend_d, last_served);
      grant_write = 1'b0;
      grant_addr  = i_addr;
      grant_wdata = '0;
      if (grant_owner == OWNER_D) begin
         grant_write = d_write;
         grant_addr  = d_addr;
         grant_wdata = d_wdata;
      end
   end

   assign serve_done = ((state == SERVE_I) || (state == SERVE_D)) && pmem_resp;

   // State and fairness history.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_served <= OWNER_I;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  state <= (grant_owner == OWNER_D) ? SERVE_D : SERVE_I;
               end
            end
            SERVE_I: begin
               if (pmem_resp) begin
                  state       <= DONE;
                  last_served <= OWNER_I;
               end
            end
            SERVE_D: begin
               if (pmem_resp) begin
                  state       <= DONE;
                  last_served <= OWNER_D;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   mem_port_arbiter_req_latch #(
      .ADDR_W(ADDR_W),
      .LINE_W(LINE_W)
   ) u_req_latch (
      .clk      (clk),
      .rst      (rst),
      .grant    (grant),
      .clear    (serve_done),
      .op_write (grant_write),
      .addr     (grant_addr),
      .wdata    (grant_wdata),
      .valid    (lat_valid),
      .is_write (lat_write),
      .lat_addr (pmem_addr),
      .lat_wdata(pmem_wdata)
   );

   // Shared-port command comes straight from the latch registers.
   assign pmem_read  = lat_valid & ~lat_write;
   assign pmem_write = lat_valid &  lat_write;

   // Response demux: same-cycle pass-through to the current owner only.
   assign i_resp  = (state == SERVE_I) && pmem_resp;
   assign d_resp  = (state == SERVE_D) && pmem_resp;
   assign i_rdata = i_resp ? pmem_rdata : '0;
   assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single-side service, arbitration
// order, write-over-read priority, dropped requests and reset mid-service.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned LW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read;
   logic [AW-1:0] i_addr;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_addr;
   logic [LW-1:0] d_wdata;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_addr;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   int vectors = 0;
   int errors  = 0;

   localparam logic [LW-1:0] LINE_A5 = {8{32'hA5A5_A5A5}};
   localparam logic [LW-1:0] LINE_3C = {8{32'h3C3C_0F0F}};
   localparam logic [LW-1:0] WD_1    = {8{32'hDEAD_BEEF}};
   localparam logic [LW-1:0] WD_2    = {8{32'h1234_5678}};

   mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_read    (i_read),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_resp    (i_resp),
      .d_read    (d_read),
      .d_write   (d_write),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_resp    (d_resp),
      .pmem_read (pmem_read),
      .pmem_write(pmem_write),
      .pmem_addr (pmem_addr),
      .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata),
      .pmem_resp (pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; inputs change and outputs are sampled 1-2 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_grant();
      for (int w = 0; w < 8 && !(pmem_read || pmem_write); w++) tick();
   endtask

   initial begin
      rst = 1'b1; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
      d_addr = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;

      // 1: reset held 2 cycles with i_read high
      i_read = 1'b1; i_addr = 32'h0000_0040;
      tick(); tick(); settle();
      chk("rst_pmem_read",  LW'(pmem_read),  '0);
      chk("rst_pmem_write", LW'(pmem_write), '0);
      chk("rst_pmem_addr",  LW'(pmem_addr),  '0);
      chk("rst_i_resp",     LW'(i_resp),     '0);
      chk("rst_d_resp",     LW'(d_resp),     '0);
      rst = 1'b0; settle();
      chk("rst_fall_no_grant", LW'(pmem_read), '0);
      tick(); settle();
      chk("first_grant_read", LW'(pmem_read), LW'(1'b1));
      chk("first_grant_addr", LW'(pmem_addr), LW'(32'h0000_0040));
      i_read = 1'b0;
      do_reset();

      // 2: I-only read, resp on cycle 4
      i_read = 1'b1; i_addr = 32'h0000_1000; settle();
      chk("i_only_c0_read", LW'(pmem_read), '0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 4) begin pmem_resp = 1'b1; pmem_rdata = LINE_A5; end
         settle();
         chk("i_only_read",  LW'(pmem_read), LW'(1'b1));
         chk("i_only_addr",  LW'(pmem_addr), LW'(32'h0000_1000));
         chk("i_only_iresp", LW'(i_resp),    LW'(c == 4));
         chk("i_only_rdata", i_rdata,        (c == 4) ? LINE_A5 : '0);
         chk("i_only_dresp", LW'(d_resp),    '0);
      end
      tick(); pmem_resp = 1'b0; i_read = 1'b0; settle();
      chk("i_only_done_read", LW'(pmem_read), '0);
      chk("i_only_done_resp", LW'(i_resp),    '0);
      tick();

      // 3: simultaneous I read and D write from reset; D first
      do_reset();
      i_read = 1'b1; i_addr = 32'h100; d_write = 1'b1; d_addr = 32'h200; d_wdata = WD_1;
      tick(); settle();
      chk("sim_d_write", LW'(pmem_write), LW'(1'b1));
      chk("sim_d_read",  LW'(pmem_read),  '0);
      chk("sim_d_addr",  LW'(pmem_addr),  LW'(32'h200));
      chk("sim_d_wdata", pmem_wdata,      WD_1);
      pmem_resp = 1'b1; pmem_rdata = LINE_3C; settle();
      chk("sim_d_resp",   LW'(d_resp), LW'(1'b1));
      chk("sim_d_rdata",  d_rdata,     LINE_3C);
      chk("sim_d_iresp",  LW'(i_resp), '0);
      chk("sim_d_irdata", i_rdata,     '0);
      tick(); pmem_resp = 1'b0; d_write = 1'b0; settle();
      chk("sim_done_write", LW'(pmem_write), '0);
      tick(); settle();
      chk("sim_idle_read", LW'(pmem_read), '0);
      tick(); settle();
      chk("sim_i_read", LW'(pmem_read), LW'(1'b1));
      chk("sim_i_addr", LW'(pmem_addr), LW'(32'h100));
      pmem_resp = 1'b1; pmem_rdata = LINE_A5; settle();
      chk("sim_i_resp",  LW'(i_resp), LW'(1'b1));
      chk("sim_i_dresp", LW'(d_resp), '0);
      tick(); pmem_resp = 1'b0; i_read = 1'b0; tick();

      // 4: both held continuously; owners D,I,D,I,D,I
      do_reset();
      i_read = 1'b1; i_addr = 32'h1000; d_read = 1'b1; d_addr = 32'h2000;
      for (int k = 0; k < 6; k++) begin
         wait_grant(); settle();
         chk("rr_granted", LW'(pmem_read || pmem_write), LW'(1'b1));
         chk("rr_addr", LW'(pmem_addr), LW'((k % 2 == 0) ? 32'h2000 : 32'h1000));
         pmem_resp = 1'b1; settle();
         chk("rr_dresp", LW'(d_resp), LW'(k % 2 == 0));
         chk("rr_iresp", LW'(i_resp), LW'(k % 2 == 1));
         tick(); pmem_resp = 1'b0;
      end
      i_read = 1'b0; d_read = 1'b0; tick(); tick();

      // 5: read+write together -> write; request dropped mid-service still completes
      do_reset();
      d_read = 1'b1; d_write = 1'b1; d_addr = 32'h300; d_wdata = WD_2;
      tick(); settle();
      chk("rw_write", LW'(pmem_write), LW'(1'b1));
      chk("rw_read",  LW'(pmem_read),  '0);
      chk("rw_addr",  LW'(pmem_addr),  LW'(32'h300));
      chk("rw_wdata", pmem_wdata,      WD_2);
      d_read = 1'b0; d_write = 1'b0; d_wdata = '0; d_addr = '0;
      tick(); settle();
      chk("drop_write", LW'(pmem_write), LW'(1'b1));
      chk("drop_wdata", pmem_wdata,      WD_2);
      pmem_resp = 1'b1; settle();
      chk("drop_dresp", LW'(d_resp), LW'(1'b1));
      tick(); pmem_resp = 1'b0; tick();

      // 6: reset in SERVE_D, stray resp 2 cycles later is ignored
      do_reset();
      d_read = 1'b1; d_addr = 32'h400;
      tick(); settle();
      chk("abort_serving", LW'(pmem_read), LW'(1'b1));
      rst = 1'b1; d_read = 1'b0;
      tick(); rst = 1'b0; settle();
      chk("abort_read", LW'(pmem_read), '0);
      chk("abort_addr", LW'(pmem_addr), '0);
      tick();
      pmem_resp = 1'b1; pmem_rdata = LINE_A5; settle();
      chk("stray_dresp",  LW'(d_resp), '0);
      chk("stray_iresp",  LW'(i_resp), '0);
      chk("stray_drdata", d_rdata,     '0);
      tick(); pmem_resp = 1'b0; settle();
      chk("stray_no_cmd", LW'(pmem_read || pmem_write), '0);
      d_read = 1'b1; d_addr = 32'h500;
      tick(); settle();
      chk("post_abort_grant", LW'(pmem_read), LW'(1'b1));
      chk("post_abort_addr",  LW'(pmem_addr), LW'(32'h500));
      d_read = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
